// File: rtl/uart_rx_axis.sv
// rtl/uart_rx_axis.sv - 8-N-1 UART receiver with a one-entry AXI-Stream output register
// Frames are timed from the shared 16x baud tick; bits are sampled mid-cell.
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  clk_en_16_x_baud,
  input  logic                  UART_RX,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic                  rx;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  tick;
  logic                  at_mid;
  logic                  at_end;
  logic                  last_bit;
  logic                  stop_take;
  logic                  xfer;

  assign rx       = sync2_q;
  assign tick     = clk_en_16_x_baud;
  assign at_mid   = (tcnt_q == 4'd7);
  assign at_end   = (tcnt_q == 4'hF);
  assign last_bit = (bcnt_q == BW'(DATA_WIDTH - 1));
  assign xfer     = tvalid_q && m_axis_tready;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE:  if (!rx) state_d = S_START;
        S_START: if (at_mid) state_d = rx ? S_IDLE : S_DATA;
        S_DATA:  if (at_end && last_bit) state_d = S_STOP;
        S_STOP:  if (at_end) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    stop_take = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          tcnt_d = '0;
        end
        S_START: begin
          tcnt_d = at_mid ? 4'd0 : tcnt_q + 4'd1;
          if (at_mid) bcnt_d = '0;
        end
        S_DATA: begin
          tcnt_d = tcnt_q + 4'd1;
          if (at_end) begin
            shreg_d = {rx, shreg_q[DATA_WIDTH-1:1]};
            bcnt_d  = bcnt_q + BW'(1);
          end
        end
        S_STOP: begin
          tcnt_d    = tcnt_q + 4'd1;
          stop_take = at_end;
        end
        default: tcnt_d = '0;
      endcase
    end

    // A byte may load on the same edge the held one is taken.
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q && !m_axis_tready;
    ferr_d   = stop_take && !rx;
    ovr_d    = 1'b0;
    if (stop_take && rx) begin
      if (!tvalid_q || xfer) begin
        tdata_d  = shreg_q;
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_error   = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb/tb_uart_rx_axis.sv - self-checking bench for uart_rx_axis
// Frames are driven bit-serially; expectations come from a byte-level delivery model.
`timescale 1ns/1ps
module tb_uart_rx_axis;
  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          reset;
  logic          clk_en_16_x_baud = 1'b0;
  logic          uart_rx;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          frame_error;
  logic          overrun;
  logic [1:0]    tick_div = '0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_q[$];
  int            fe_cnt = 0;
  int            ovr_cnt = 0;
  int            vcyc_cnt = 0;
  int            both_cnt = 0;

  logic [DW-1:0] exp_q[$];
  int            exp_fe = 0;
  int            exp_ovr = 0;
  bit            held = 0;
  logic [DW-1:0] held_byte = '0;
  bit            rdy_level = 0;
  int            seen = 0;

  uart_rx_axis #(.DATA_WIDTH(DW)) dut (
    .aclk             (aclk),
    .reset            (reset),
    .clk_en_16_x_baud (clk_en_16_x_baud),
    .UART_RX          (uart_rx),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .frame_error      (frame_error),
    .overrun          (overrun)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    tick_div         <= tick_div + 2'd1;
    clk_en_16_x_baud <= (tick_div == 2'd2);
  end

  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    if (m_axis_tvalid) vcyc_cnt <= vcyc_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_error && overrun) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge aclk);
      while (!clk_en_16_x_baud) @(posedge aclk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit, input bit rdy_at_stop);
    uart_rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DW; i++) begin
      uart_rx = b[i];
      wait_ticks(16);
    end
    uart_rx = stop_bit;
    if (rdy_at_stop) begin
      // raise tready only in the aclk cycle that ends on the stop-sample tick
      wait_ticks(8);
      repeat (3) @(posedge aclk);
      #1 m_axis_tready = 1'b1;
      wait_ticks(8);
    end else begin
      wait_ticks(16);
    end
    uart_rx = 1'b1;
  endtask

  task automatic model_frame(input logic [DW-1:0] b, input logic stop_bit);
    if (!stop_bit) exp_fe++;
    else if (rdy_level) exp_q.push_back(b);
    else if (!held) begin
      held      = 1;
      held_byte = b;
    end else exp_ovr++;
  endtask

  task automatic model_ready(input bit r);
    rdy_level = r;
    if (r && held) begin
      exp_q.push_back(held_byte);
      held = 0;
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (seen < got_q.size() && seen < exp_q.size()) begin
      check({tag, "_byte"}, got_q[seen], exp_q[seen]);
      seen++;
    end
    check({tag, "_ferr"}, fe_cnt, exp_fe);
    check({tag, "_ovr"}, ovr_cnt, exp_ovr);
  endtask

  initial begin
    logic [DW-1:0] b;
    logic          sb;
    int            v0;
    int            gap;

    reset         = 1'b1;
    uart_rx       = 1'b1;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    wait_ticks(20);

    m_axis_tready = 1'b1;
    model_ready(1);
    v0 = vcyc_cnt;
    send_frame(8'hA5, 1'b1, 0);
    model_frame(8'hA5, 1'b1);
    wait_ticks(4);
    compare_stream("single");
    check("single_vcycles", vcyc_cnt - v0, 1);

    uart_rx = 1'b0;
    wait_ticks(4);
    uart_rx = 1'b1;
    wait_ticks(40);
    compare_stream("glitch");
    send_frame(8'h3C, 1'b1, 0);
    model_frame(8'h3C, 1'b1);
    wait_ticks(4);
    compare_stream("after_glitch");

    v0 = vcyc_cnt;
    send_frame(8'h3C, 1'b0, 0);
    model_frame(8'h3C, 1'b0);
    wait_ticks(24);
    compare_stream("framing");
    check("framing_vcycles", vcyc_cnt - v0, 0);

    m_axis_tready = 1'b0;
    model_ready(0);
    send_frame(8'h11, 1'b1, 0);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1, 0);
    model_frame(8'h22, 1'b1);
    wait_ticks(4);
    check("ovr_tvalid_held", m_axis_tvalid, 1);
    check("ovr_tdata_held", m_axis_tdata, 8'h11);
    compare_stream("overrun");
    m_axis_tready = 1'b1;
    model_ready(1);
    wait_ticks(2);
    compare_stream("ovr_release");
    check("ovr_tvalid_after", m_axis_tvalid, 0);

    m_axis_tready = 1'b0;
    model_ready(0);
    send_frame(8'h00, 1'b1, 0);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, 1);
    model_ready(1);
    model_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1, 0);
    model_frame(8'h55, 1'b1);
    wait_ticks(4);
    compare_stream("b2b");

    m_axis_tready = 1'b0;
    model_ready(0);
    send_frame(8'h77, 1'b1, 0);
    model_frame(8'h77, 1'b1);
    wait_ticks(4);
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    check("pre_rst_tdata", m_axis_tdata, 8'h77);
    b = 8'hC3;
    uart_rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      wait_ticks(16);
    end
    uart_rx = b[4];
    wait_ticks(8);
    reset = 1'b1;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check("midrst_ferr", frame_error, 0);
    check("midrst_ovr", overrun, 0);
    uart_rx = 1'b1;
    held    = 0;
    repeat (4) @(posedge aclk);
    #1 reset = 1'b0;
    wait_ticks(20);
    m_axis_tready = 1'b1;
    model_ready(1);
    send_frame(8'h5A, 1'b1, 0);
    model_frame(8'h5A, 1'b1);
    wait_ticks(4);
    compare_stream("after_reset");

    for (int k = 0; k < 10; k++) begin
      b  = DW'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(b, sb, 0);
      model_frame(b, sb);
      gap = sb ? int'($urandom_range(0, 6)) : 20;
      if (gap > 0) wait_ticks(gap);
    end
    wait_ticks(24);
    compare_stream("random");
    check("ferr_ovr_together", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
